// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared types and constants for the jump button input path
package dino_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } deb_state_e;

    localparam int R20_BTN_BITS           = 3;
    localparam int DEBOUNCE_CYCLES_100MHZ = 1000000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer plus stable-level debounce FSM
module btn_debounce
    import dino_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic button_level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    deb_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   btn_s;

    // Pure flop chain: nothing combinational may sit ahead of the last stage.
    assign btn_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], button_raw};
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_LOW: begin
                if (btn_s) begin
                    state_d = S_RISE;
                    cnt_d   = '0;
                end
            end
            S_RISE: begin
                if (!btn_s)                state_d = S_LOW;
                else if (cnt_q == CNT_LAST) state_d = S_HIGH;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            S_HIGH: begin
                if (!btn_s) begin
                    state_d = S_FALL;
                    cnt_d   = '0;
                end
            end
            S_FALL: begin
                if (btn_s)                 state_d = S_HIGH;
                else if (cnt_q == CNT_LAST) state_d = S_LOW;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == S_HIGH) || (state_d == S_FALL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign button_level = level_q;

endmodule

// File: rtl/jump_input_conditioner.sv
// rtl/jump_input_conditioner.sv - jump button to frame-aligned request; JUMP_REPEAT_EN adds hold auto-repeat
module jump_input_conditioner
    import dino_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
    parameter int REPEAT_FRAMES   = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        button_raw,
    input  logic        frame_tick,
    input  logic        jump_ack,
    output logic        button_level,
    output logic        jump_req,
    output logic        press_drop,
    output logic [31:0] r20_word
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_FRAMES < 1) begin : g_bad_cfg
        $error("jump_input_conditioner: invalid parameter set");
    end

    logic level_prev_q, level_prev_d;
    logic pend_q, pend_d;
    logic jump_req_q, jump_req_d;
    logic press_drop_q, press_drop_d;
    logic press_evt, promote, rep_fire;

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .button_raw  (button_raw),
        .button_level(button_level)
    );

`ifdef JUMP_REPEAT_EN
    localparam int FW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

    logic [FW-1:0] frm_cnt_q, frm_cnt_d;

    always_comb begin
        frm_cnt_d = frm_cnt_q;
        rep_fire  = 1'b0;
        if (!button_level) begin
            frm_cnt_d = '0;
        end else if (frame_tick) begin
            if (frm_cnt_q == FW'(REPEAT_FRAMES - 1)) begin
                frm_cnt_d = '0;
                rep_fire  = 1'b1;
            end else begin
                frm_cnt_d = frm_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) frm_cnt_q <= '0;
        else        frm_cnt_q <= frm_cnt_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    // A press arriving on the promotion edge stays pending; a new request beats a same-edge ack.
    always_comb begin
        press_evt    = button_level && !level_prev_q;
        promote      = frame_tick && pend_q;
        level_prev_d = button_level;
        pend_d       = press_evt || rep_fire || (pend_q && !promote);
        press_drop_d = press_drop_q || (press_evt && pend_q);
        jump_req_d   = jump_req_q;
        if (jump_ack) jump_req_d = 1'b0;
        if (promote)  jump_req_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_prev_q <= 1'b0;
            pend_q       <= 1'b0;
            jump_req_q   <= 1'b0;
            press_drop_q <= 1'b0;
        end else begin
            level_prev_q <= level_prev_d;
            pend_q       <= pend_d;
            jump_req_q   <= jump_req_d;
            press_drop_q <= press_drop_d;
        end
    end

    assign jump_req   = jump_req_q;
    assign press_drop = press_drop_q;
    assign r20_word   = {{(32-R20_BTN_BITS){1'b0}}, {R20_BTN_BITS{jump_req_q}}};

endmodule

// File: tb/tb_jump_input_conditioner.sv
// tb/tb_jump_input_conditioner.sv - vector table, corner sequences and random run against a reference model
module tb_jump_input_conditioner;

    localparam int DEB = 8;
    localparam int REP = 3;
`ifdef JUMP_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        button_raw, frame_tick, jump_ack;
    logic        button_level, jump_req, press_drop;
    logic [31:0] r20_word;

    int checks = 0;
    int failures = 0;

    jump_input_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_FRAMES  (REP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .button_raw  (button_raw),
        .frame_tick  (frame_tick),
        .jump_ack    (jump_ack),
        .button_level(button_level),
        .jump_req    (jump_req),
        .press_drop  (press_drop),
        .r20_word    (r20_word)
    );

    always #5 clk = ~clk;

    // Reference model: raw pin delayed two samples; level flips once DEB+1 consecutive
    // samples disagree with it; requests follow the pending/promotion rules.
    typedef struct {
        bit s0, s1, lvl, prev, pend, req, drop;
        int streak;
        int held_ticks;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_step(mdl_t c, bit raw, bit tick, bit ack);
        mdl_t n = c;
        bit pe, fire, prom;
        n.s0 = raw;
        n.s1 = c.s0;
        pe = c.lvl && !c.prev;
        n.prev = c.lvl;
        if (c.s1 != c.lvl) begin
            if (c.streak == DEB) begin
                n.lvl = c.s1;
                n.streak = 0;
            end else begin
                n.streak = c.streak + 1;
            end
        end else begin
            n.streak = 0;
        end
        fire = 1'b0;
        if (!c.lvl) n.held_ticks = 0;
        else if (tick) begin
            n.held_ticks = c.held_ticks + 1;
            fire = REP_EN && ((n.held_ticks % REP) == 0);
        end
        prom = tick && c.pend;
        if (pe && c.pend) n.drop = 1'b1;
        if (prom) n.req = 1'b1;
        else if (ack) n.req = 1'b0;
        n.pend = pe || fire || (c.pend && !prom);
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '{default: 0};
        else        m <= mdl_step(m, button_raw, frame_tick, jump_ack);
    end

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit t, input bit a);
        button_raw = r;
        frame_tick = t;
        jump_ack   = a;
        @(negedge clk);
        chk("model", 40'({button_level, jump_req, press_drop, r20_word}),
            40'({m.lvl, m.req, m.drop, 29'd0, {3{m.req}}}));
    endtask

    task automatic hold(input bit r, input int n);
        for (int k = 0; k < n; k++) cyc(r, 1'b0, 1'b0);
    endtask

    task automatic chk_out(input string nm, input bit lvl, input bit req, input bit drop);
        chk({nm, "_level"}, 40'(button_level), 40'(lvl));
        chk({nm, "_req"}, 40'(jump_req), 40'(req));
        chk({nm, "_drop"}, 40'(press_drop), 40'(drop));
        chk({nm, "_r20"}, 40'(r20_word), req ? 40'h7 : 40'h0);
    endtask

    typedef struct {
        bit raw, tick, ack;
        int n;
        bit lvl, req, drop;
    } vec_t;

    vec_t vt[23];

    initial begin
        vt = '{
            '{1,0,0,10, 0,0,0}, '{1,0,0,1, 1,0,0}, '{1,0,0,1, 1,0,0}, '{1,1,0,1, 1,1,0},
            '{0,0,0,12, 0,1,0}, '{1,0,0,12, 1,1,0}, '{1,1,1,1, 1,1,0}, '{1,0,1,1, 1,0,0},
            '{1,1,0,1, 1,0,0},
            '{0,0,0,12, 0,0,0}, '{1,0,0,12, 1,0,0}, '{0,0,0,12, 0,0,0}, '{1,0,0,12, 1,0,1},
            '{1,1,0,1, 1,1,1}, '{1,0,1,1, 1,0,1}, '{1,1,0,1, 1,0,1},
            '{0,0,0,12, 0,0,1}, '{1,0,0,12, 1,0,1}, '{0,0,0,12, 0,0,1}, '{1,0,0,11, 1,0,1},
            '{1,1,0,1, 1,1,1}, '{1,0,1,1, 1,0,1}, '{1,1,0,1, 1,1,1}
        };

        reset = 1'b0;
        button_raw = 1'b0;
        frame_tick = 1'b0;
        jump_ack = 1'b0;
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        chk_out("reset", 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 23; i++) begin
            cyc(vt[i].raw, vt[i].tick, vt[i].ack);
            hold(vt[i].raw, vt[i].n - 1);
            chk_out($sformatf("vec%0d", i), vt[i].lvl, vt[i].req, vt[i].drop);
        end

        // Async reset while debouncing a new press and with a request outstanding.
        hold(1'b0, 12);
        hold(1'b1, 6);
        chk("pre_rst_req", 40'(jump_req), 40'd1);
        #2 reset = 1'b0;
        #1 chk("rst_async", 40'({button_level, jump_req, press_drop, r20_word}), 40'd0);
        @(negedge clk);
        hold(1'b1, 3);
        reset = 1'b1;
        hold(1'b1, 10);
        chk("rst_redeb_early", 40'(button_level), 40'd0);
        hold(1'b1, 1);
        chk("rst_redeb_level", 40'(button_level), 40'd1);
        hold(1'b1, 1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("rst_redeb_req", 40'(jump_req), 40'd1);
        cyc(1'b1, 1'b0, 1'b1);

        // Bounce: 3-cycle toggles never settle, then the final hold debounces once.
        hold(1'b0, 12);
        for (int i = 0; i < 40; i++) cyc(((i / 3) % 2) == 0, 1'b0, 1'b0);
        chk("bounce_level", 40'(button_level), 40'd0);
        hold(1'b1, 10);
        chk("bounce_early", 40'(button_level), 40'd0);
        hold(1'b1, 1);
        chk("bounce_level_up", 40'(button_level), 40'd1);
        hold(1'b1, 1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("bounce_req", 40'(jump_req), 40'd1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("bounce_single", 40'(jump_req), 40'd0);

        // Held button through seven frame ticks.
        hold(1'b0, 12);
        hold(1'b1, 12);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk($sformatf("repeat_tick%0d", i), 40'(jump_req),
                40'((i == 0) || (REP_EN && (i % 3 == 0))));
            cyc(1'b1, 1'b0, 1'b1);
            chk($sformatf("repeat_ack%0d", i), 40'(jump_req), 40'd0);
            hold(1'b1, 2);
        end
        hold(1'b0, 12);

        for (int s = 0; s < 220; s++) begin
            int len;
            bit r;
            r = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 24);
            for (int k = 0; k < len; k++)
                cyc(r, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            if (s == 110) begin
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
